// File: rtl/reservation_station_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : reservation_station_if                                 |
// | Description : Issue, common-data-bus, fullness and dispatch signals  |
// |               of one reservation station, grouped as an interface.   |
// |               master = issuer/CDB/execution-unit side,               |
// |               slave  = reservation station.                          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface reservation_station_if #(
  parameter int XLEN      = 32,
  parameter int TAG_WIDTH = 6
);
  // two-wide issue bus (slot 0 is the older instruction)
  logic [1:0]                           in_valid;
  logic [1:0][2:0]                      in_type;
  logic [1:0][7:0]                      in_name;
  logic [1:0][XLEN-1:0]                 in_address;
  logic [1:0][XLEN-1:0]                 in_immediate;
  logic [1:0][1:0][TAG_WIDTH-1:0]       in_src_tag;
  logic [1:0][1:0][XLEN-1:0]            in_src_value;
  logic [1:0][1:0]                      in_src_ready;
  logic [1:0][TAG_WIDTH-1:0]            in_dest_tag;
  // common data bus
  logic                                 cdb_valid;
  logic [TAG_WIDTH-1:0]                 cdb_tag;
  logic [XLEN-1:0]                      cdb_result;
  // fullness back to the issuer
  logic                                 full;
  // dispatch to the execution unit
  logic                                 out_valid;
  logic                                 out_ready;
  logic [7:0]                           out_name;
  logic [XLEN-1:0]                      out_address;
  logic [XLEN-1:0]                      out_immediate;
  logic [XLEN-1:0]                      out_src1;
  logic [XLEN-1:0]                      out_src2;
  logic [TAG_WIDTH-1:0]                 out_dest_tag;

  modport master (
    output in_valid, in_type, in_name, in_address, in_immediate,
           in_src_tag, in_src_value, in_src_ready, in_dest_tag,
           cdb_valid, cdb_tag, cdb_result, out_ready,
    input  full, out_valid, out_name, out_address, out_immediate,
           out_src1, out_src2, out_dest_tag
  );

  modport slave (
    input  in_valid, in_type, in_name, in_address, in_immediate,
           in_src_tag, in_src_value, in_src_ready, in_dest_tag,
           cdb_valid, cdb_tag, cdb_result, out_ready,
    output full, out_valid, out_name, out_address, out_immediate,
           out_src1, out_src2, out_dest_tag
  );
endinterface
`default_nettype wire

// File: rtl/reservation_station.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : reservation_station                                    |
// | Description : SIZE-entry reservation station for one execution type. |
// |               Accepts up to two instructions per cycle, snoops the   |
// |               CDB for missing operands and dispatches one ready      |
// |               instruction per cycle over a valid/ready handshake.    |
// | Option      : RS_AGE_ORDER_EN - oldest-eligible selection using a    |
// |               saturating per-entry age counter (default: lowest      |
// |               index eligible).                                       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module reservation_station #(
  parameter int SIZE         = 8,
  parameter int XLEN         = 32,
  parameter int TAG_WIDTH    = 6,
  parameter int STATION_TYPE = 0
) (
  input  logic                    clock,
  input  logic                    reset,   // asynchronous, active low
  input  logic                    flush,
  reservation_station_if.slave    rs
);

  localparam int IW = $clog2(SIZE);
  localparam int CW = IW + 1;
`ifdef RS_AGE_ORDER_EN
  localparam int              AW      = IW + 1;
  localparam logic [AW-1:0]   AGE_MAX = '1;
`endif

  typedef struct packed {
    logic                           valid;
    logic [7:0]                     name;
    logic [XLEN-1:0]                address;
    logic [XLEN-1:0]                immediate;
    logic [1:0][TAG_WIDTH-1:0]      tag;
    logic [1:0][XLEN-1:0]           value;
    logic [1:0]                     ready;
    logic [TAG_WIDTH-1:0]           dest;
`ifdef RS_AGE_ORDER_EN
    logic [AW-1:0]                  age;
`endif
  } entry_t;

  entry_t               entry_q [SIZE];
  entry_t               entry_d [SIZE];
  logic [CW-1:0]        count_q, count_d;
  logic                 full_q, full_d;
  logic                 out_valid_q, out_valid_d;
  logic [7:0]           out_name_q, out_name_d;
  logic [XLEN-1:0]      out_address_q, out_address_d;
  logic [XLEN-1:0]      out_immediate_q, out_immediate_d;
  logic [XLEN-1:0]      out_src1_q, out_src1_d;
  logic [XLEN-1:0]      out_src2_q, out_src2_d;
  logic [TAG_WIDTH-1:0] out_dest_tag_q, out_dest_tag_d;

  logic [1:0]           accept;
  logic [1:0][IW-1:0]   slot_idx;
  logic                 sel_found;
  logic [IW-1:0]        sel_idx;
  logic                 load;
  logic                 dispatch;
`ifdef RS_AGE_ORDER_EN
  logic [AW-1:0]        best_age;
`endif

  // Accept decision per issue slot and the free entry each accepted slot lands in
  always_comb begin
    slot_idx = '0;
    for (int s = 0; s < 2; s++) begin
      accept[s] = rs.in_valid[s] && (rs.in_type[s] == 3'(STATION_TYPE)) && !full_q;
    end
    // slot 0: lowest free entry of the current state
    for (int e = SIZE - 1; e >= 0; e--) begin
      if (!entry_q[e].valid) slot_idx[0] = IW'(e);
    end
    // slot 1: lowest free entry not already claimed by slot 0
    for (int e = SIZE - 1; e >= 0; e--) begin
      if (!entry_q[e].valid && !(accept[0] && (IW'(e) == slot_idx[0]))) slot_idx[1] = IW'(e);
    end
  end

  // Pick the entry to dispatch among those with both operands ready
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
`ifdef RS_AGE_ORDER_EN
    best_age  = '0;
    // strictly-greater compare keeps the lowest index on age ties
    for (int e = 0; e < SIZE; e++) begin
      if (entry_q[e].valid && (&entry_q[e].ready) &&
          (!sel_found || (entry_q[e].age > best_age))) begin
        sel_found = 1'b1;
        sel_idx   = IW'(e);
        best_age  = entry_q[e].age;
      end
    end
`else
    for (int e = SIZE - 1; e >= 0; e--) begin
      if (entry_q[e].valid && (&entry_q[e].ready)) begin
        sel_found = 1'b1;
        sel_idx   = IW'(e);
      end
    end
`endif
  end

  assign load     = !out_valid_q || rs.out_ready;
  assign dispatch = load && sel_found;

  // Next state: flush overrides everything; otherwise age, wakeup, dispatch, write
  always_comb begin
    entry_d         = entry_q;
    count_d         = count_q;
    full_d          = full_q;
    out_valid_d     = out_valid_q;
    out_name_d      = out_name_q;
    out_address_d   = out_address_q;
    out_immediate_d = out_immediate_q;
    out_src1_d      = out_src1_q;
    out_src2_d      = out_src2_q;
    out_dest_tag_d  = out_dest_tag_q;

    if (flush) begin
      for (int e = 0; e < SIZE; e++) entry_d[e].valid = 1'b0;
      count_d     = '0;
      full_d      = 1'b0;
      out_valid_d = 1'b0;
    end else begin
`ifdef RS_AGE_ORDER_EN
      for (int e = 0; e < SIZE; e++) begin
        if (entry_q[e].valid && (entry_q[e].age != AGE_MAX)) entry_d[e].age = entry_q[e].age + AW'(1);
      end
`endif
      // CDB wakeup of resident entries; both sources may match at once
      if (rs.cdb_valid) begin
        for (int e = 0; e < SIZE; e++) begin
          for (int k = 0; k < 2; k++) begin
            if (entry_q[e].valid && !entry_q[e].ready[k] && (entry_q[e].tag[k] == rs.cdb_tag)) begin
              entry_d[e].ready[k] = 1'b1;
              entry_d[e].value[k] = rs.cdb_result;
            end
          end
        end
      end

      // output register reloads whenever it is empty or being consumed
      if (load) begin
        if (sel_found) begin
          out_valid_d              = 1'b1;
          out_name_d               = entry_q[sel_idx].name;
          out_address_d            = entry_q[sel_idx].address;
          out_immediate_d          = entry_q[sel_idx].immediate;
          out_src1_d               = entry_q[sel_idx].value[0];
          out_src2_d               = entry_q[sel_idx].value[1];
          out_dest_tag_d           = entry_q[sel_idx].dest;
          entry_d[sel_idx].valid   = 1'b0;
        end else begin
          out_valid_d = 1'b0;
        end
      end

      // writes land only in entries free at the start of the cycle
      for (int s = 0; s < 2; s++) begin
        if (accept[s]) begin
          entry_d[slot_idx[s]].valid     = 1'b1;
          entry_d[slot_idx[s]].name      = rs.in_name[s];
          entry_d[slot_idx[s]].address   = rs.in_address[s];
          entry_d[slot_idx[s]].immediate = rs.in_immediate[s];
          entry_d[slot_idx[s]].tag       = rs.in_src_tag[s];
          entry_d[slot_idx[s]].dest      = rs.in_dest_tag[s];
          for (int k = 0; k < 2; k++) begin
            // same-cycle CDB bypass for a not-yet-ready source
            if (rs.in_src_ready[s][k]) begin
              entry_d[slot_idx[s]].ready[k] = 1'b1;
              entry_d[slot_idx[s]].value[k] = rs.in_src_value[s][k];
            end else begin
              entry_d[slot_idx[s]].ready[k] = rs.cdb_valid && (rs.cdb_tag == rs.in_src_tag[s][k]);
              entry_d[slot_idx[s]].value[k] = rs.cdb_result;
            end
          end
`ifdef RS_AGE_ORDER_EN
          // the older slot starts one tick ahead so program order survives a dual write
          entry_d[slot_idx[s]].age = ((s == 0) && accept[1]) ? AW'(1) : '0;
`endif
        end
      end

      count_d = count_q + CW'(accept[0]) + CW'(accept[1]) - CW'(dispatch);
      full_d  = (count_d > CW'(SIZE - 2));
    end
  end

  // State register with asynchronous active-low reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int e = 0; e < SIZE; e++) entry_q[e] <= '0;
      count_q         <= '0;
      full_q          <= 1'b0;
      out_valid_q     <= 1'b0;
      out_name_q      <= '0;
      out_address_q   <= '0;
      out_immediate_q <= '0;
      out_src1_q      <= '0;
      out_src2_q      <= '0;
      out_dest_tag_q  <= '0;
    end else begin
      entry_q         <= entry_d;
      count_q         <= count_d;
      full_q          <= full_d;
      out_valid_q     <= out_valid_d;
      out_name_q      <= out_name_d;
      out_address_q   <= out_address_d;
      out_immediate_q <= out_immediate_d;
      out_src1_q      <= out_src1_d;
      out_src2_q      <= out_src2_d;
      out_dest_tag_q  <= out_dest_tag_d;
    end
  end

  assign rs.full          = full_q;
  assign rs.out_valid     = out_valid_q;
  assign rs.out_name      = out_name_q;
  assign rs.out_address   = out_address_q;
  assign rs.out_immediate = out_immediate_q;
  assign rs.out_src1      = out_src1_q;
  assign rs.out_src2      = out_src2_q;
  assign rs.out_dest_tag  = out_dest_tag_q;

endmodule
`default_nettype wire

// File: tb/tb_reservation_station.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_reservation_station                                 |
// | Description : Self-checking bench: directed scenarios followed by    |
// |               random traffic against a behavioural station model.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_reservation_station;

  localparam int SIZE = 8;
  localparam int XLEN = 32;
  localparam int TW   = 6;
  localparam int ST   = 0;

  logic clock = 1'b0;
  logic reset;
  logic flush;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  reservation_station_if #(.XLEN(XLEN), .TAG_WIDTH(TW)) bus ();

  reservation_station #(
    .SIZE(SIZE), .XLEN(XLEN), .TAG_WIDTH(TW), .STATION_TYPE(ST)
  ) dut (
    .clock(clock),
    .reset(reset),
    .flush(flush),
    .rs(bus)
  );

  // behavioural model: an array of entries plus the output register contents
  typedef struct packed {
    bit              v;
    bit [7:0]        name;
    bit [31:0]       addr;
    bit [31:0]       imm;
    bit [1:0][5:0]   tag;
    bit [1:0][31:0]  val;
    bit [1:0]        rdy;
    bit [5:0]        dest;
    bit [7:0]        age;
  } ment_t;

  ment_t m [SIZE];
  ment_t mo;
  bit    mo_valid;
  bit    m_full;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int e = 0; e < SIZE; e++) m[e] = '0;
    mo       = '0;
    mo_valid = 1'b0;
    m_full   = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.in_valid     = '0;
    bus.in_type      = '0;
    bus.in_name      = '0;
    bus.in_address   = '0;
    bus.in_immediate = '0;
    bus.in_src_tag   = '0;
    bus.in_src_value = '0;
    bus.in_src_ready = '0;
    bus.in_dest_tag  = '0;
    bus.cdb_valid    = 1'b0;
    bus.cdb_tag      = '0;
    bus.cdb_result   = '0;
    bus.out_ready    = 1'b1;
    flush            = 1'b0;
  endtask

  task automatic set_slot(input int s, input bit [31:0] v1, input bit [31:0] v2,
                          input bit r1, input bit r2, input bit [5:0] t1,
                          input bit [5:0] t2, input bit [5:0] d);
    bus.in_valid[s]        = 1'b1;
    bus.in_type[s]         = 3'(ST);
    bus.in_name[s]         = 8'($urandom);
    bus.in_address[s]      = $urandom;
    bus.in_immediate[s]    = $urandom;
    bus.in_src_value[s][0] = v1;
    bus.in_src_value[s][1] = v2;
    bus.in_src_ready[s][0] = r1;
    bus.in_src_ready[s][1] = r2;
    bus.in_src_tag[s][0]   = t1;
    bus.in_src_tag[s][1]   = t2;
    bus.in_dest_tag[s]     = d;
  endtask

  task automatic random_inputs();
    bus.in_valid = 2'($urandom);
    for (int s = 0; s < 2; s++) begin
      bus.in_type[s]      = 3'($urandom_range(0, 1));
      bus.in_name[s]      = 8'($urandom);
      bus.in_address[s]   = $urandom;
      bus.in_immediate[s] = $urandom;
      bus.in_dest_tag[s]  = 6'($urandom_range(0, 15));
      for (int k = 0; k < 2; k++) begin
        bus.in_src_tag[s][k]   = 6'($urandom_range(0, 7));
        bus.in_src_value[s][k] = $urandom;
        bus.in_src_ready[s][k] = ($urandom_range(0, 2) != 0);
      end
    end
    bus.cdb_valid  = 1'($urandom_range(0, 1));
    bus.cdb_tag    = 6'($urandom_range(0, 7));
    bus.cdb_result = $urandom;
    bus.out_ready  = ($urandom_range(0, 3) != 0);
    flush          = ($urandom_range(0, 99) == 0);
  endtask

  task automatic compare_outputs();
    check("out_valid",     64'(bus.out_valid),     64'(mo_valid));
    check("full",          64'(bus.full),          64'(m_full));
    check("out_name",      64'(bus.out_name),      64'(mo.name));
    check("out_address",   64'(bus.out_address),   64'(mo.addr));
    check("out_immediate", 64'(bus.out_immediate), 64'(mo.imm));
    check("out_src1",      64'(bus.out_src1),      64'(mo.val[0]));
    check("out_src2",      64'(bus.out_src2),      64'(mo.val[1]));
    check("out_dest_tag",  64'(bus.out_dest_tag),  64'(mo.dest));
  endtask

  // apply the station's rules to the current inputs, clock once, compare
  task automatic step();
    ment_t nxt [SIZE];
    int    free_q [$];
    bit [1:0] acc;
    int    pick;
    int    idx;
    int    occupied;
    if (flush) begin
      for (int e = 0; e < SIZE; e++) m[e].v = 1'b0;
      mo_valid = 1'b0;
      m_full   = 1'b0;
    end else begin
      nxt = m;
      for (int e = 0; e < SIZE; e++)
        if (m[e].v && m[e].age < 8'(2 * SIZE - 1)) nxt[e].age = m[e].age + 8'd1;
      if (!mo_valid || bus.out_ready) begin
        pick = -1;
        for (int e = 0; e < SIZE; e++) begin
          if (m[e].v && m[e].rdy == 2'b11) begin
`ifdef RS_AGE_ORDER_EN
            if (pick < 0 || m[e].age > m[pick].age) pick = e;
`else
            if (pick < 0) pick = e;
`endif
          end
        end
        if (pick >= 0) begin
          mo          = m[pick];
          mo_valid    = 1'b1;
          nxt[pick].v = 1'b0;
        end else begin
          mo_valid = 1'b0;
        end
      end
      if (bus.cdb_valid)
        for (int e = 0; e < SIZE; e++)
          for (int k = 0; k < 2; k++)
            if (m[e].v && !m[e].rdy[k] && m[e].tag[k] == bus.cdb_tag) begin
              nxt[e].rdy[k] = 1'b1;
              nxt[e].val[k] = bus.cdb_result;
            end
      for (int e = 0; e < SIZE; e++) if (!m[e].v) free_q.push_back(e);
      for (int s = 0; s < 2; s++) acc[s] = bus.in_valid[s] && bus.in_type[s] == 3'(ST) && !m_full;
      for (int s = 0; s < 2; s++) begin
        if (acc[s]) begin
          idx            = free_q.pop_front();
          nxt[idx].v     = 1'b1;
          nxt[idx].name  = bus.in_name[s];
          nxt[idx].addr  = bus.in_address[s];
          nxt[idx].imm   = bus.in_immediate[s];
          nxt[idx].dest  = bus.in_dest_tag[s];
          nxt[idx].tag   = bus.in_src_tag[s];
          nxt[idx].age   = (s == 0 && acc[1]) ? 8'd1 : 8'd0;
          for (int k = 0; k < 2; k++) begin
            if (bus.in_src_ready[s][k]) begin
              nxt[idx].rdy[k] = 1'b1;
              nxt[idx].val[k] = bus.in_src_value[s][k];
            end else begin
              nxt[idx].rdy[k] = bus.cdb_valid && bus.cdb_tag == bus.in_src_tag[s][k];
              nxt[idx].val[k] = bus.cdb_result;
            end
          end
        end
      end
      m = nxt;
      occupied = 0;
      for (int e = 0; e < SIZE; e++) if (m[e].v) occupied++;
      m_full = (SIZE - occupied) < 2;
    end
    @(posedge clock);
    #1;
    compare_outputs();
  endtask

  initial begin
    model_reset();
    idle_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_full",      64'(bus.full),      64'd0);
    check("rst_out_src1",  64'(bus.out_src1),  64'd0);
    compare_outputs();
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // single ready instruction: visible one cycle after its write edge
    set_slot(0, 32'd5, 32'd7, 1'b1, 1'b1, 6'd1, 6'd2, 6'd3);
    step();
    check("t1_not_yet", 64'(bus.out_valid), 64'd0);
    idle_inputs();
    step();
    check("t1_valid", 64'(bus.out_valid),    64'd1);
    check("t1_src1",  64'(bus.out_src1),     64'd5);
    check("t1_src2",  64'(bus.out_src2),     64'd7);
    check("t1_dest",  64'(bus.out_dest_tag), 64'd3);
    check("t1_full",  64'(bus.full),         64'd0);
    step();

    // operand wakeup from the CDB
    set_slot(0, 32'd1, 32'd0, 1'b1, 1'b0, 6'd20, 6'd9, 6'd4);
    step();
    idle_inputs();
    step();
    bus.cdb_valid = 1'b1; bus.cdb_tag = 6'd9; bus.cdb_result = 32'hABCD;
    step();
    check("t2_wait", 64'(bus.out_valid), 64'd0);
    idle_inputs();
    step();
    check("t2_valid", 64'(bus.out_valid), 64'd1);
    check("t2_src2",  64'(bus.out_src2),  64'h0000ABCD);
    step();

    // fill with the execution unit stalled, then drain
    for (int c = 0; c < 5; c++) begin
      idle_inputs();
      bus.out_ready = 1'b0;
      set_slot(0, $urandom, $urandom, 1'b1, 1'b1, 6'd0, 6'd0, 6'(c));
      set_slot(1, $urandom, $urandom, 1'b1, 1'b1, 6'd0, 6'd0, 6'(c + 8));
      step();
    end
    check("t3_full", 64'(bus.full), 64'd1);
    idle_inputs();
    for (int c = 0; c < 10; c++) step();
    check("t3_drained_full", 64'(bus.full),      64'd0);
    check("t3_drained_vld",  64'(bus.out_valid), 64'd0);

    // same-cycle CDB bypass on write
    set_slot(0, 32'd0, 32'd3, 1'b0, 1'b1, 6'd4, 6'd0, 6'd5);
    bus.cdb_valid = 1'b1; bus.cdb_tag = 6'd4; bus.cdb_result = 32'h11;
    step();
    idle_inputs();
    step();
    check("t4_valid", 64'(bus.out_valid), 64'd1);
    check("t4_src1",  64'(bus.out_src1),  64'h11);
    step();

    // flush with a loaded station and live issue
    for (int c = 0; c < 3; c++) begin
      idle_inputs();
      bus.out_ready = 1'b0;
      set_slot(0, $urandom, $urandom, 1'b1, 1'b1, 6'd0, 6'd0, 6'd1);
      set_slot(1, $urandom, $urandom, 1'b1, 1'b1, 6'd0, 6'd0, 6'd2);
      step();
    end
    check("t5_pre_valid", 64'(bus.out_valid), 64'd1);
    bus.out_ready = 1'b0;
    flush = 1'b1;
    step();
    check("t5_flush_valid", 64'(bus.out_valid), 64'd0);
    check("t5_flush_full",  64'(bus.full),      64'd0);
    idle_inputs();
    step();
    step();
    check("t5_no_dispatch", 64'(bus.out_valid), 64'd0);

    // random traffic with one asynchronous reset mid-run
    for (int c = 0; c < 3000; c++) begin
      random_inputs();
      step();
      if (c == 1500) begin
        #2;
        reset = 1'b0;
        #1;
        check("midrst_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_full",  64'(bus.full),      64'd0);
        check("midrst_src1",  64'(bus.out_src1),  64'd0);
        model_reset();
        @(negedge clock);
        reset = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Receiving end of the issue/fullness protocol.
- Buffers up to SIZE instructions of one execution type, as sent by the two-wide issuer.
- Snoops the common data bus (CDB) for missing source operands.
- Dispatches ready instructions one per cycle to its execution unit over a valid/ready handshake.
- Reports `full` back to the issuer's fullness bus.

Parameters:
- SIZE, 8, number of entries (power of two, at least 4).
- XLEN, 32, data/address width.
- TAG_WIDTH, 6, rename tag width.
- STATION_TYPE, 0, instr_type code this station accepts (AL/BR/LS/MD encoding).

Ports:
- clock  in  1  single clock; everything sampled on rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous pipeline flush (mispredict).
- in_valid  in  2  per-slot issue valid (slot 0 is older).
- in_type  in  2x3  per-slot instr_type.
- in_name  in  2x8  per-slot instr_name code.
- in_address  in  2xXLEN  per-slot instruction address.
- in_immediate  in  2xXLEN  per-slot immediate.
- in_src_tag  in  2x2xTAG_WIDTH  source tags (rs1, rs2).
- in_src_value  in  2x2xXLEN  source values, meaningful when ready.
- in_src_ready  in  2x2  source value already available.
- in_dest_tag  in  2xTAG_WIDTH  destination tag.
- cdb_valid  in  1  result broadcast valid.
- cdb_tag  in  TAG_WIDTH  broadcast tag.
- cdb_result  in  XLEN  broadcast value.
- full  out  1  fewer than two free entries.
- out_valid  out  1  dispatch valid.
- out_ready  in  1  execution unit accepts.
- out_name, out_address, out_immediate, out_src1, out_src2, out_dest_tag  out  8/XLEN/XLEN/XLEN/XLEN/TAG_WIDTH  dispatched instruction.

Behaviour:
- Reset (reset low, asynchronous):
  - All entry valid bits, out_valid and full go to 0.
  - All out_* data go to 0.
- Accept:
  - Slot i is written when in_valid[i] && in_type[i]==STATION_TYPE && !full.
  - Slots for other types are ignored.
  - Slot 0 takes the lowest-index free entry; slot 1 takes the next one.
  - Free mask is taken from the current state; entries freed in the same cycle are not reused until the next cycle.
- Bypass on write: if cdb_valid and cdb_tag matches a not-ready incoming source, that source is stored as ready with cdb_result.
- Wakeup: each edge with cdb_valid, every valid entry's non-ready source whose tag equals cdb_tag captures cdb_result and sets ready. Both sources may match in the same cycle.
- Selection:
  - An entry is eligible when valid and both sources are ready.
  - Output register loads when !out_valid || out_ready.
  - It loads the lowest-index eligible entry, or the oldest when the optional feature is enabled.
  - The loaded entry is freed on the same edge.
  - An entry written at edge E reaches out_valid at edge E+1 at the earliest; with ready operands and out_ready=1 this sustains one per cycle.
- Handshake:
  - out_* are held stable while out_valid && !out_ready.
  - If nothing is eligible when the register is consumed, out_valid drops to 0.
- Occupancy:
  - next_count = count + accepted - dispatched.
  - full <= (SIZE - next_count) < 2. Registered, so the issuer sees it the cycle after.
  - No overflow is possible because full blocks acceptance with a margin of two.
- Flush:
  - Clears all entries and out_valid on the next edge.
  - Has priority over accept, wakeup and dispatch in the same cycle.
  - full returns to 0.
- Reset mid-operation: all in-flight state is discarded immediately; there is no partial dispatch.

Optional Feature:
- Macro: RS_AGE_ORDER_EN.
- Defined:
  - Each entry carries a log2(SIZE)+1-bit age counter, set to 0 on write and incremented each cycle while valid, saturating.
  - Selection picks the eligible entry with the largest age; ties go to the lowest index.
  - Slot 0 is written with age 1 when both slots write in the same cycle, so program order is preserved.
- Undefined: no age storage; selection is lowest-index eligible.

Test Plan:
- Reset, then issue slot0 (type match, both sources ready, src1=5, src2=7, dest 3) -> out_valid=1 one cycle after the write edge, out_src1=5, out_src2=7, out_dest_tag=3; full=0.
- Issue entry with src2 not ready, tag 9; two cycles later cdb_valid, tag 9, result 0xABCD -> out_valid the following cycle with out_src2=0xABCD.
- Hold out_ready=0 and issue two slots per cycle until full -> full=1 once 7 of 8 entries are occupied; further in_valid is ignored; out_* stay stable; raising out_ready drains one per cycle and full clears when free entries reach at least 2.
- Same-cycle CDB and issue: in_src_tag=4 not ready with cdb tag 4, value 0x11 -> entry stored ready and dispatched with out_src1=0x11.
- Flush while 5 entries are held and out_valid=1, with in_valid=2'b11 that cycle -> next cycle out_valid=0, full=0, no further dispatch.
- With RS_AGE_ORDER_EN: write entry A (blocked on tag 2), then B (ready) into a lower freed index, then broadcast tag 2 -> A dispatched before any later-written ready entry, B dispatched first since it was eligible earlier.
